pipeline_ctrl: RTL and testbench
================================

Name: pipeline_ctrl

Overview:
- Control end of the five-stage pipeline register bank.
- Consumes stage state already held in the IF/ID, ID/EX, EX/MEM and MEM/WB latches, plus the ihit and dhit cache handshakes.
- Produces per-latch enable and flush strobes, and the PC enable.
- Implements the memory-wait freeze, the load-use bubble, branch/jump redirect flush and halt drain, with saturating stall/flush performance counters.

Parameters:
CNT_W, 16, width of the stall and flush performance counters

Ports:
CLK  in  1  system clock, rising edge
nRST  in  1  asynchronous active-low reset
ihit  in  1  instruction fetch completed this cycle
dhit  in  1  data access completed this cycle
instr_id  in  32  instruction currently in IF/ID
ex_dren  in  1  ID/EX holds a load
ex_wsel  in  5  load destination register in ID/EX
mem_dren  in  1  EX/MEM holds a load
mem_dwen  in  1  EX/MEM holds a store
mem_redirect  in  1  taken beq/bne, j, jal or JR resolved in MEM
wb_halt  in  1  halt in MEM/WB
pc_en  out  1  PC register update enable
en_1  out  1  IF/ID enable
en_2  out  1  ID/EX enable
en_3  out  1  EX/MEM enable
en_4  out  1  MEM/WB enable
flush_1  out  1  IF/ID load bubble (zero contents) on next edge
flush_2  out  1  ID/EX load bubble
flush_3  out  1  EX/MEM load bubble
halted  out  1  pipeline halted, sticky
stall_cnt  out  CNT_W  cycles with pc_en=0 outside HALT
flush_cnt  out  CNT_W  accepted redirects

Behaviour:
- CLK is the only clock. nRST is asynchronous, active-low.
- Reset:
  - state=IDLE; counters=0; halted=0.
  - While nRST=0 and in IDLE, all en_*/flush_*/pc_en are 0.
  - IDLE moves to RUN on the first edge after release.
- States: IDLE, RUN, MEMWAIT, HALT.
- Derived signals:
  - dreq = mem_dren | mem_dwen.
  - freeze = dreq & ~dhit.
  - lu = ex_dren & ex_wsel!=0 & (ex_wsel==instr_id[25:21] | ex_wsel==instr_id[20:16]). Conservative: rt is compared for all opcodes.
- Outputs are combinational from state and inputs. Priority order is HALT > freeze > redirect > load-use > ifetch miss > normal.
- HALT, or RUN with wb_halt=1:
  - All en=0, flush=0, pc_en=0.
  - Go to HALT. halted=1 from the following cycle until reset.
- freeze (RUN or MEMWAIT):
  - pc_en=en_1=en_2=en_3=en_4=0, flush=0.
  - Next state MEMWAIT. MEMWAIT returns to RUN on the cycle dhit=1, and that cycle evaluates as RUN.
- redirect (mem_redirect=1, no freeze):
  - All en=1, pc_en=1, flush_1=flush_2=flush_3=1.
  - flush_cnt+1.
  - The redirect target is selected by the datapath, not this block.
  - ihit=0 does not delay the flush; pc_en is still 1 so the new target is fetched.
- load-use (lu=1, no freeze, no redirect):
  - pc_en=0, en_1=0, flush_2=1, en_2..en_4=1.
  - Exactly one bubble is inserted. The next cycle the load is in EX/MEM, so lu deasserts naturally.
- ifetch miss (ihit=0 otherwise):
  - pc_en=0, flush_1=1, en_1..en_4=1, so the younger stages keep draining.
- normal: all en=1, pc_en=1, flush=0.
- Counters:
  - stall_cnt increments on any cycle in RUN/MEMWAIT with pc_en=0.
  - Both counters saturate at all-ones and never wrap.
  - A redirect and a stall in the same cycle cannot both count stall, since pc_en=1 on a redirect.
- Simultaneous events:
  - wb_halt together with freeze: halt wins. The MEM access is abandoned.
  - Reset mid-freeze: immediate return to IDLE, counters cleared.

Decomposition:
- State enum pctrl_state_t (IDLE, RUN, MEMWAIT, HALT) and the field positions RS_MSB/RS_LSB/RT_MSB/RT_LSB go in cpu_types_pkg, beside regbits_t.
- One sub-module, sat_counter (parameter W, inputs inc and clear, output q), instantiated twice.

Test Plan:
- Reset release, ihit=1, no hazards -> IDLE outputs 0 during reset; from cycle 1 all en=1, pc_en=1, counters 0.
- mem_dren=1 with dhit low for 3 cycles then high -> 3 cycles all en=0; stall_cnt=3; cycle 4 all en=1, state RUN.
- ex_dren=1, ex_wsel=5, instr_id rs=5 -> one cycle pc_en=0, en_1=0, flush_2=1; next cycle normal; stall_cnt=1.
- mem_redirect=1 with ihit=0 -> flush_1..3=1, pc_en=1, flush_cnt=1.
- mem_redirect=1 during freeze -> no flush until dhit=1, then one flush cycle, flush_cnt=1.
- wb_halt=1 alongside mem_dwen=1 and dhit=0 -> halted=1 next cycle and stays 1; all en=0; counters frozen; nRST pulse clears.
- Force 2^CNT_W+5 stall cycles -> stall_cnt holds 0xFFFF.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register index, instruction word, instruction field
// positions and the pipeline controller state and control-bundle types.
package cpu_types_pkg;

    localparam int WORD_W = 32;
    localparam int REG_W  = 5;

    typedef logic [REG_W-1:0]  regbits_t;
    typedef logic [WORD_W-1:0] word_t;

    // Source register fields of an R/I-type instruction word.
    localparam int RS_MSB = 25;
    localparam int RS_LSB = 21;
    localparam int RT_MSB = 20;
    localparam int RT_LSB = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        MEMWAIT = 2'd2,
        HALT    = 2'd3
    } pctrl_state_t;

    // Everything the controller drives into the latch bank in one cycle.
    typedef struct packed {
        logic pc_en;
        logic en_1;
        logic en_2;
        logic en_3;
        logic en_4;
        logic flush_1;
        logic flush_2;
        logic flush_3;
    } pctrl_ctl_t;

    function automatic regbits_t rs_field(input word_t instr);
        return instr[RS_MSB:RS_LSB];
    endfunction

    function automatic regbits_t rt_field(input word_t instr);
        return instr[RT_MSB:RT_LSB];
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; synchronous clear.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         CLK,
    input  logic         nRST,
    input  logic         inc,
    input  logic         clear,
    output logic [W-1:0] q
);

    localparam logic [W-1:0] ONE = W'(1);

    // Count register: clear wins over increment, increment stops at all-ones.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            q <= '0;
        end else if (clear) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + ONE;
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Control end of the five-stage pipeline register bank: latch enables,
// bubble strobes, PC enable, halt drain and stall/flush performance counters.
module pipeline_ctrl
    import cpu_types_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic [31:0]      instr_id,
    input  logic             ex_dren,
    input  logic [4:0]       ex_wsel,
    input  logic             mem_dren,
    input  logic             mem_dwen,
    input  logic             mem_redirect,
    input  logic             wb_halt,
    output logic             pc_en,
    output logic             en_1,
    output logic             en_2,
    output logic             en_3,
    output logic             en_4,
    output logic             flush_1,
    output logic             flush_2,
    output logic             flush_3,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    pctrl_state_t state;
    pctrl_state_t next_state;
    pctrl_ctl_t   ctl;

    logic dreq;
    logic freeze;
    logic lu;
    logic active;
    logic halt_now;
    logic stall_inc;
    logic flush_inc;
    logic cnt_clear;
    logic unused_instr_bits;

    // Only the rs/rt fields matter for hazard detection.
    assign unused_instr_bits = ^{instr_id[31:26], instr_id[15:0]};

    // A data access still outstanding freezes every latch and the PC.
    assign dreq   = mem_dren | mem_dwen;
    assign freeze = dreq & ~dhit;

    // Load in EX feeding the instruction in ID; rt is compared for every
    // opcode, so some non-readers of rt stall needlessly but never wrongly.
    assign lu = ex_dren && (ex_wsel != '0) &&
                ((ex_wsel == rs_field(instr_id)) || (ex_wsel == rt_field(instr_id)));

    // MEMWAIT evaluates exactly like RUN; it only records that we are frozen.
    assign active   = (state == RUN) || (state == MEMWAIT);
    assign halt_now = (state == HALT) || (active && wb_halt);

    // State register.
    // NOTE: sequential state uses non-blocking assignment so every flop samples
    // pre-edge values regardless of block evaluation order.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state: leave IDLE after reset, track freeze, latch halt forever.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: next_state = RUN;
            RUN, MEMWAIT: begin
                if (wb_halt) begin
                    next_state = HALT;
                end else if (freeze) begin
                    next_state = MEMWAIT;
                end else begin
                    next_state = RUN;
                end
            end
            HALT:    next_state = HALT;
            default: next_state = IDLE;
        endcase
    end

    // Outputs: priority halt > freeze > redirect > load-use > ifetch miss > normal.
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        ctl       = '0;
        flush_inc = 1'b0;
        if (active && !halt_now) begin
            if (freeze) begin
                ctl = '0;
            end else if (mem_redirect) begin
                ctl       = '1;
                flush_inc = 1'b1;
            end else if (lu) begin
                ctl.en_2    = 1'b1;
                ctl.en_3    = 1'b1;
                ctl.en_4    = 1'b1;
                ctl.flush_2 = 1'b1;
            end else if (!ihit) begin
                ctl.en_1    = 1'b1;
                ctl.en_2    = 1'b1;
                ctl.en_3    = 1'b1;
                ctl.en_4    = 1'b1;
                ctl.flush_1 = 1'b1;
            end else begin
                ctl.pc_en = 1'b1;
                ctl.en_1  = 1'b1;
                ctl.en_2  = 1'b1;
                ctl.en_3  = 1'b1;
                ctl.en_4  = 1'b1;
            end
        end
    end

    assign pc_en   = ctl.pc_en;
    assign en_1    = ctl.en_1;
    assign en_2    = ctl.en_2;
    assign en_3    = ctl.en_3;
    assign en_4    = ctl.en_4;
    assign flush_1 = ctl.flush_1;
    assign flush_2 = ctl.flush_2;
    assign flush_3 = ctl.flush_3;
    assign halted  = (state == HALT);

    // Any active cycle that holds the PC is a stall; a redirect always moves it.
    assign stall_inc = active & ~ctl.pc_en;
    assign cnt_clear = (state == IDLE);

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .CLK   (CLK),
        .nRST  (nRST),
        .inc   (stall_inc),
        .clear (cnt_clear),
        .q     (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .CLK   (CLK),
        .nRST  (nRST),
        .inc   (flush_inc),
        .clear (cnt_clear),
        .q     (flush_cnt)
    );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: stimulus pushes the reference model's
// expectation per cycle, a monitor pops and compares on the falling edge.
module tb_pipeline_ctrl;

    localparam int CNT_W   = 16;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    // {pc_en, en_1, en_2, en_3, en_4, flush_1, flush_2, flush_3}
    localparam logic [7:0] CTL_OFF   = 8'b0_0000_000;
    localparam logic [7:0] CTL_NORM  = 8'b1_1111_000;
    localparam logic [7:0] CTL_REDIR = 8'b1_1111_111;
    localparam logic [7:0] CTL_LU    = 8'b0_0111_010;
    localparam logic [7:0] CTL_MISS  = 8'b0_1111_100;

    logic             CLK;
    logic             nRST;
    logic             ihit;
    logic             dhit;
    logic [31:0]      instr_id;
    logic             ex_dren;
    logic [4:0]       ex_wsel;
    logic             mem_dren;
    logic             mem_dwen;
    logic             mem_redirect;
    logic             wb_halt;
    logic             pc_en;
    logic             en_1;
    logic             en_2;
    logic             en_3;
    logic             en_4;
    logic             flush_1;
    logic             flush_2;
    logic             flush_3;
    logic             halted;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    pipeline_ctrl #(.CNT_W(CNT_W)) dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .ihit         (ihit),
        .dhit         (dhit),
        .instr_id     (instr_id),
        .ex_dren      (ex_dren),
        .ex_wsel      (ex_wsel),
        .mem_dren     (mem_dren),
        .mem_dwen     (mem_dwen),
        .mem_redirect (mem_redirect),
        .wb_halt      (wb_halt),
        .pc_en        (pc_en),
        .en_1         (en_1),
        .en_2         (en_2),
        .en_3         (en_3),
        .en_4         (en_4),
        .flush_1      (flush_1),
        .flush_2      (flush_2),
        .flush_3      (flush_3),
        .halted       (halted),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] ctl;
        logic       halted;
        int         stall;
        int         flush;
        int         cyc;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int cur_cyc  = 0;

    // Reference model: has the pipeline left reset, has it halted, counters.
    bit m_live   = 1'b0;
    bit m_halted = 1'b0;
    int m_stall  = 0;
    int m_flush  = 0;

    task automatic check(input string name, input longint act, input longint req);
        n_checks++;
        if (act == req) begin
            n_pass++;
        end else begin
            $display("FAIL %s at cycle %0d: got 0x%0h, required 0x%0h", name, cur_cyc, act, req);
        end
    endtask

    function automatic int sat_inc(input int v);
        return (v < CNT_MAX) ? v + 1 : v;
    endfunction

    // Drive one cycle of inputs and push what the controller must answer.
    task automatic step(input logic r, input logic ih, input logic dh,
                        input logic [31:0] ins, input logic exd, input logic [4:0] exw,
                        input logic md, input logic mw, input logic rd, input logic wh);
        exp_t e;
        bit   frz;
        bit   luse;
        @(posedge CLK);
        #1;
        nRST = r; ihit = ih; dhit = dh; instr_id = ins; ex_dren = exd;
        ex_wsel = exw; mem_dren = md; mem_dwen = mw; mem_redirect = rd; wb_halt = wh;
        e.cyc = cyc;
        cyc++;
        e.ctl = CTL_OFF;
        if (!r) begin
            m_live = 1'b0; m_halted = 1'b0; m_stall = 0; m_flush = 0;
            e.halted = 1'b0; e.stall = 0; e.flush = 0;
        end else begin
            e.halted = m_halted;
            e.stall  = m_stall;
            e.flush  = m_flush;
            if (!m_live) begin
                m_live = 1'b1;
            end else if (m_halted) begin
                e.ctl = CTL_OFF;
            end else if (wh) begin
                m_halted = 1'b1;
                m_stall  = sat_inc(m_stall);
            end else begin
                frz  = (md || mw) && !dh;
                luse = exd && (exw != 5'd0) && (exw == ins[25:21] || exw == ins[20:16]);
                if (frz) begin
                    e.ctl = CTL_OFF;
                end else if (rd) begin
                    e.ctl   = CTL_REDIR;
                    m_flush = sat_inc(m_flush);
                end else if (luse) begin
                    e.ctl = CTL_LU;
                end else if (!ih) begin
                    e.ctl = CTL_MISS;
                end else begin
                    e.ctl = CTL_NORM;
                end
                if (!e.ctl[7]) m_stall = sat_inc(m_stall);
            end
        end
        sb.push_back(e);
    endtask

    task automatic run_norm(input int n);
        for (int i = 0; i < n; i++) step(1, 1, 0, 32'd0, 0, 5'd0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        step(0, 1, 0, 32'd0, 0, 5'd0, 0, 0, 0, 0);
        step(0, 1, 0, 32'd0, 0, 5'd0, 0, 0, 0, 0);
        step(1, 1, 0, 32'd0, 0, 5'd0, 0, 0, 0, 0);
    endtask

    // Monitor: outputs are settled on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                cur_cyc = e.cyc;
                check("ctl", {pc_en, en_1, en_2, en_3, en_4, flush_1, flush_2, flush_3}, e.ctl);
                check("halted", halted, e.halted);
                check("stall_cnt", stall_cnt, e.stall);
                check("flush_cnt", flush_cnt, e.flush);
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, required normal end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        nRST = 0; ihit = 0; dhit = 0; instr_id = '0; ex_dren = 0;
        ex_wsel = '0; mem_dren = 0; mem_dwen = 0; mem_redirect = 0; wb_halt = 0;

        // Reset held, then release into normal flow.
        repeat (3) step(0, 1, 0, 32'd0, 0, 5'd0, 0, 0, 0, 0);
        step(1, 1, 0, 32'd0, 0, 5'd0, 0, 0, 0, 0);
        run_norm(4);

        // Load waiting three cycles on dhit, then completing.
        repeat (3) step(1, 1, 0, 32'd0, 0, 5'd0, 1, 0, 0, 0);
        step(1, 1, 1, 32'd0, 0, 5'd0, 1, 0, 0, 0);
        run_norm(2);

        // Load-use on rs, then on rt, then a $zero destination that must not stall.
        do_reset();
        run_norm(1);
        step(1, 1, 0, 32'h00A0_0000, 1, 5'd5, 0, 0, 0, 0);
        run_norm(1);
        step(1, 1, 0, 32'h0007_0000, 1, 5'd7, 0, 0, 0, 0);
        step(1, 1, 0, 32'h0000_0000, 1, 5'd0, 0, 0, 0, 0);
        run_norm(1);

        // Redirect with an ifetch miss still flushes and moves the PC.
        do_reset();
        run_norm(1);
        step(1, 0, 0, 32'd0, 0, 5'd0, 0, 0, 1, 0);
        run_norm(2);

        // Redirect held behind a freeze, accepted once dhit arrives.
        do_reset();
        run_norm(1);
        repeat (2) step(1, 1, 0, 32'd0, 0, 5'd0, 0, 1, 1, 0);
        step(1, 1, 1, 32'd0, 0, 5'd0, 0, 1, 1, 0);
        run_norm(2);

        // Reset pulled in the middle of a freeze.
        repeat (2) step(1, 1, 0, 32'd0, 0, 5'd0, 1, 0, 0, 0);
        do_reset();
        run_norm(2);

        // Halt alongside an unfinished store, activity while halted, then reset.
        step(1, 1, 0, 32'd0, 0, 5'd0, 0, 1, 0, 1);
        step(1, 0, 0, 32'd0, 0, 5'd0, 0, 0, 1, 0);
        step(1, 1, 0, 32'h00A0_0000, 1, 5'd5, 1, 0, 0, 0);
        run_norm(3);
        do_reset();
        run_norm(2);

        // Stall counter saturation through a long ifetch miss.
        do_reset();
        repeat (CNT_MAX + 6) step(1, 0, 0, 32'd0, 0, 5'd0, 0, 0, 0, 0);
        step(1, 1, 0, 32'd0, 0, 5'd0, 0, 0, 1, 0);
        step(1, 0, 0, 32'd0, 0, 5'd0, 0, 0, 0, 0);
        run_norm(2);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] ins;
            ins = $urandom;
            ins[25:21] = 5'($urandom_range(0, 7));
            ins[20:16] = 5'($urandom_range(0, 7));
            step(($urandom_range(0, 99) >= 2), ($urandom_range(0, 99) < 80),
                 1'($urandom_range(0, 1)), ins, ($urandom_range(0, 99) < 30),
                 5'($urandom_range(0, 7)), ($urandom_range(0, 99) < 20),
                 ($urandom_range(0, 99) < 10), ($urandom_range(0, 99) < 12),
                 ($urandom_range(0, 99) < 2));
        end

        @(negedge CLK);
        #1;
        check("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
